regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_writer_pkg.sv | 25 ++
 rtl/regfile_writer.sv | 118 +++++++++++
 tb/tb_regfile_writer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writer_pkg.sv
// Shared defines for the write-back serialiser: widths, register-file geometry, state encoding.
`default_nettype none

package regfile_writer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ID_W   = BYTE_W;

  localparam int              REGNUM_DEF = 8;
  localparam logic [ID_W-1:0] NOREG_DEF  = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_E = 2'd1,
    ST_WR_M = 2'd2
  } state_t;

  function automatic logic id_in_range(input logic [ID_W-1:0] id, input int regnum);
    return ({{(32-ID_W){1'b0}}, id} < 32'(regnum));
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_writer.sv
// +----------------------------------------------------------------------------+
// | regfile_writer: turns an (E, M) write-back pair into single-port writes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int              REGNUM = REGNUM_DEF,
  parameter logic [ID_W-1:0] NOREG  = NOREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ID_W-1:0]   dstE,
  input  logic [WORD_W-1:0] valE,
  input  logic [ID_W-1:0]   dstM,
  input  logic [WORD_W-1:0] valM,
  output logic              wr_en,
  output logic [ID_W-1:0]   wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  state_t            w_accept_tgt;
  logic [ID_W-1:0]   r_dst_e;
  logic [ID_W-1:0]   r_dst_m;
  logic [WORD_W-1:0] r_val_e;
  logic [WORD_W-1:0] r_val_m;
  logic              r_need_m;
  logic              r_bad;
  logic              r_err;

  logic w_ready;
  logic w_accept;
  logic w_need_e_in;
  logic w_need_m_in;
  logic w_bad_in;

  // When both IDs name the same register only the memory result is kept.
  assign w_need_m_in = (dstM != NOREG) && id_in_range(dstM, REGNUM);
  assign w_need_e_in = (dstE != NOREG) && id_in_range(dstE, REGNUM) && (dstE != dstM);
  assign w_bad_in    = ((dstE != NOREG) && !id_in_range(dstE, REGNUM)) ||
                       ((dstM != NOREG) && !id_in_range(dstM, REGNUM));

  assign w_accept     = wb_valid && w_ready;
  assign w_accept_tgt = w_need_e_in ? ST_WR_E : (w_need_m_in ? ST_WR_M : ST_IDLE);

  always_comb begin
    w_ready = 1'b0;
    w_next  = ST_IDLE;
    wr_en   = 1'b0;
    wr_addr = NOREG;
    wr_data = '0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        w_next  = w_accept ? w_accept_tgt : ST_IDLE;
      end
      ST_WR_E: begin
        w_ready = !r_need_m;
        wr_en   = 1'b1;
        wr_addr = r_dst_e;
        wr_data = r_val_e;
        if (r_need_m) w_next = ST_WR_M;
        else          w_next = w_accept ? w_accept_tgt : ST_IDLE;
      end
      ST_WR_M: begin
        w_ready = 1'b1;
        wr_en   = 1'b1;
        wr_addr = r_dst_m;
        wr_data = r_val_m;
        w_next  = w_accept ? w_accept_tgt : ST_IDLE;
      end
      default: begin
        w_ready = 1'b0;
        w_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_dst_e  <= NOREG;
      r_dst_m  <= NOREG;
      r_val_e  <= '0;
      r_val_m  <= '0;
      r_need_m <= 1'b0;
      r_bad    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      // The range violation is latched at accept and folded into err one edge later.
      r_bad   <= w_accept && w_bad_in;
      r_err   <= r_err | r_bad;
      if (w_accept) begin
        r_dst_e  <= dstE;
        r_dst_m  <= dstM;
        r_val_e  <= valE;
        r_val_m  <= valM;
        r_need_m <= w_need_m_in;
      end
    end
  end

  assign wb_ready = w_ready;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed scenarios plus a randomized run against a write-queue model.
`default_nettype none

module tb_regfile_writer;

  localparam logic [7:0] NR = 8'h0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [7:0]  dstE = NR;
  logic [31:0] valE = '0;
  logic [7:0]  dstM = NR;
  logic [31:0] valM = '0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  // Model: queue of writes still owed; head is the write presented this cycle.
  wr_t mq[$];
  logic m_err  = 1'b0;
  logic m_pend = 1'b0;

  regfile_writer #(.REGNUM(8), .NOREG(8'h0F)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic vid(input logic [7:0] id);
    return (id != NR) && (id < 8'd8);
  endfunction

  function automatic logic bad(input logic [7:0] id);
    return (id != NR) && (id >= 8'd8);
  endfunction

  task automatic drive(input logic v, input logic [7:0] de, input logic [31:0] ve,
                       input logic [7:0] dm, input logic [31:0] vm);
    wb_valid = v; dstE = de; valE = ve; dstM = dm; valM = vm;
  endtask

  task automatic tick();
    logic acc;
    wr_t  t;
    @(posedge clk);
    acc = wb_valid && (mq.size() <= 1);
    if (rst) begin
      mq.delete();
      m_err  = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (mq.size() > 0) t = mq.pop_front();
      m_err  = m_err | m_pend;
      m_pend = 1'b0;
      if (acc) begin
        if (vid(dstE) && dstE != dstM) mq.push_back('{a: dstE, d: valE});
        if (vid(dstM)) mq.push_back('{a: dstM, d: valM});
        m_pend = bad(dstE) || bad(dstM);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, NR, 0, NR, 0);
    tick(); tick();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy, err, wb_ready} !== {1'b0, NR, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: got en=%b addr=%h data=%h busy=%b err=%b rdy=%b, want 0 0f 0 0 0 1",
               wr_en, wr_addr, wr_data, busy, err, wb_ready);
    end
    drive(1'b1, 8'd1, 32'hDEAD0001, 8'd2, 32'hDEAD0002);
    tick();
    rst = 1'b0;
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_blocks_accept: got en=%b busy=%b, want 0 0", wr_en, busy);
    end
    tick();
  endtask

  task automatic test_two_write();
    drive(1'b1, 8'd2, 32'h11111111, 8'd5, 32'h22222222);
    tick();
    // Not ready here: this changed request must be ignored.
    drive(1'b1, 8'd6, 32'h33333333, 8'd6, 32'h44444444);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, wb_ready} !== {1'b1, 8'd2, 32'h11111111, 1'b0}) begin
      n_errors++;
      $display("FAIL two_write_first: got en=%b addr=%h data=%h rdy=%b, want 1 02 11111111 0",
               wr_en, wr_addr, wr_data, wb_ready);
    end
    tick();
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, wb_ready} !== {1'b1, 8'd5, 32'h22222222, 1'b1}) begin
      n_errors++;
      $display("FAIL two_write_second: got en=%b addr=%h data=%h rdy=%b, want 1 05 22222222 1",
               wr_en, wr_addr, wr_data, wb_ready);
    end
    tick();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b0, NR, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL two_write_idle: got en=%b addr=%h data=%h busy=%b, want 0 0f 0 0",
               wr_en, wr_addr, wr_data, busy);
    end
  endtask

  task automatic test_same_dst();
    drive(1'b1, 8'd3, 32'hAAAA0000, 8'd3, 32'hBBBB0000);
    tick();
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'd3, 32'hBBBB0000}) begin
      n_errors++;
      $display("FAIL same_dst_write: got en=%b addr=%h data=%h, want 1 03 bbbb0000", wr_en, wr_addr, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL same_dst_single: got en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_noreg();
    drive(1'b1, NR, 32'h12345678, NR, 32'h87654321);
    tick();
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if ({wr_en, busy, wb_ready} !== 3'b001) begin
      n_errors++;
      $display("FAIL noreg_idle: got en=%b busy=%b rdy=%b, want 0 0 1", wr_en, busy, wb_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  regs [3] = '{8'd0, 8'd1, 8'd7};
    logic [31:0] vals [3] = '{32'hC0C0_0000, 32'hC1C1_1111, 32'hC7C7_7777};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, regs[i], vals[i], NR, 32'hFFFF_FFFF);
      tick();
      n_checks++;
      if ({wr_en, wr_addr, wr_data, wb_ready} !== {1'b1, regs[i], vals[i], 1'b1}) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got en=%b addr=%h data=%h rdy=%b, want 1 %h %h 1",
                 i, wr_en, wr_addr, wr_data, wb_ready, regs[i], vals[i]);
      end
    end
    drive(1'b0, NR, 0, NR, 0);
    tick();
  endtask

  task automatic test_err();
    drive(1'b1, 8'h09, 32'h99999999, 8'd4, 32'h44440000);
    tick();
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, err} !== {1'b1, 8'd4, 32'h44440000, 1'b0}) begin
      n_errors++;
      $display("FAIL err_m_only: got en=%b addr=%h data=%h err=%b, want 1 04 44440000 0",
               wr_en, wr_addr, wr_data, err);
    end
    tick();
    n_checks++;
    if ({wr_en, err} !== 2'b01) begin
      n_errors++;
      $display("FAIL err_set: got en=%b err=%b, want 0 1", wr_en, err);
    end
    drive(1'b1, 8'd1, 32'h1, NR, 0);
    tick(); tick(); tick();
    drive(1'b0, NR, 0, NR, 0);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got err=%b, want 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_clear: got err=%b, want 0", err);
    end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 8'd2, 32'h5A5A5A5A, 8'd5, 32'hA5A5A5A5);
    tick();
    drive(1'b0, NR, 0, NR, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy, err, wb_ready} !== {1'b0, NR, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL rst_mid: got en=%b addr=%h data=%h busy=%b err=%b rdy=%b, want 0 0f 0 0 0 1",
               wr_en, wr_addr, wr_data, busy, err, wb_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ids [2];
    logic        e_en;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        r = $urandom_range(0, 11);
        ids[k] = (r >= 10) ? NR : 8'(r);
      end
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 9) < 7, ids[0], $urandom, ids[1], $urandom);
      tick();
      e_en   = (mq.size() > 0);
      e_addr = e_en ? mq[0].a : NR;
      e_data = e_en ? mq[0].d : 32'h0;
      n_checks++;
      if ({wr_en, wr_addr, wr_data, busy, wb_ready, err} !==
          {e_en, e_addr, e_data, e_en, (mq.size() <= 1), m_err}) begin
        n_errors++;
        $display("FAIL random[%0d]: got en=%b addr=%h data=%h busy=%b rdy=%b err=%b, want %b %h %h %b %b %b",
                 c, wr_en, wr_addr, wr_data, busy, wb_ready, err,
                 e_en, e_addr, e_data, e_en, (mq.size() <= 1), m_err);
      end
    end
    rst = 1'b0;
    drive(1'b0, NR, 0, NR, 0);
  endtask

  initial begin
    test_reset();
    test_two_write();
    test_same_dst();
    test_noreg();
    test_back_to_back();
    test_err();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
